row_config_loader: RTL and testbench
====================================

ROW_CONFIG_LOADER -- requirements
Module: row_config_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 69, meaning configuration bytes per load.
REQ-002 SHALL have parameter PROG_W, default 552, meaning active configuration width, fixed at 8*NUM_BYTES.
REQ-003 SHALL have port clb_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a load; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel a load in progress.
REQ-007 SHALL have port cfg_data  input  8  configuration or checksum byte.
REQ-008 SHALL have port cfg_valid  input  1  cfg_data valid.
REQ-009 SHALL have port cfg_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port prog  output  PROG_W  active row configuration driven to the 8-cell row.
REQ-011 SHALL have port busy  output  1  high in LOAD or CSUM.
REQ-012 SHALL have port done  output  1  one-cycle pulse after a successful commit.
REQ-013 SHALL have port error  output  1  sticky checksum-mismatch flag.

Function
REQ-014 SHALL implement states IDLE, LOAD and CSUM; cfg_ready, busy and done SHALL be registered or derived from registered state only.
REQ-015 A byte SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both high; cfg_ready SHALL be 1 in LOAD and CSUM and 0 in IDLE.
REQ-016 IDLE: start=1 and abort=0 SHALL move to LOAD, clear the byte counter, zero the running checksum and clear error.
REQ-017 LOAD: accepted byte k (k = 0..NUM_BYTES-1) SHALL be written to shadow bits [8k+7:8k]; byte 0 therefore lands in prog[7:0], the cell1 region.
REQ-018 LOAD: each accepted byte SHALL be XORed into an 8-bit running checksum.
REQ-019 LOAD: acceptance of byte NUM_BYTES-1 SHALL move to CSUM; the counter SHALL never wrap within a load.
REQ-020 CSUM: on acceptance of a byte equal to the running checksum, the same edge SHALL copy shadow to prog and move to IDLE, and done SHALL be 1 for exactly the following cycle.
REQ-021 CSUM: on acceptance of a mismatching byte, the same edge SHALL set error and move to IDLE; prog SHALL stay unchanged and done SHALL stay 0.
REQ-022 prog SHALL change only per REQ-020 or reset; partially loaded data SHALL never reach prog.
REQ-023 abort=1 in LOAD or CSUM SHALL move to IDLE on the next edge with no byte accepted that edge; prog and error SHALL stay unchanged.
REQ-024 abort in IDLE SHALL have no effect; start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-025 start in LOAD or CSUM SHALL be ignored.
REQ-026 Stalls, i.e. cfg_valid=0 for any number of cycles in LOAD or CSUM, SHALL hold all state; there SHALL be no timeout.
REQ-027 error SHALL remain set until the next accepted start (REQ-016) or reset.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, prog=0, shadow=0, counter=0, checksum=0, cfg_ready=0, busy=0, done=0 and error=0, independent of clb_clk.
REQ-029 rst asserted mid-load SHALL discard the load; after release the block SHALL be in IDLE awaiting start.

Verification
REQ-030 Happy path: start, bytes 0x00..0x44 (value = index), checksum 0x44 -> prog[7:0]=0x00, prog[551:544]=0x44; done high exactly one cycle after the checksum edge; error=0.
REQ-031 Mismatch: start, 69 bytes of 0xA5, checksum 0x00 -> error=1, prog unchanged from the previous value, done never asserted; a following start clears error.
REQ-032 Backpressure: the REQ-030 load with cfg_valid low for 3 cycles between every byte -> identical prog; busy high throughout.
REQ-033 Abort: start, 30 bytes, abort=1 -> IDLE next edge, prog unchanged; a fresh load of 69 bytes of 0xA5 with checksum 0xA5 -> committed correctly.
REQ-034 Reset mid-load: rst pulsed after 40 bytes, asynchronously between clock edges -> prog=0, busy=0 and cfg_ready=0 immediately; start and byte inputs ignored while rst is high.
REQ-035 Contention: start held high through a whole load, plus start and abort together in IDLE -> no restart during the load, no load entered from IDLE.

Source files
------------

// File: rtl/row_config_loader_if.sv
// row_config_loader_if: load-control, byte-stream and row-output bundle for row_config_loader.
//   master: drives start, abort, cfg_data, cfg_valid; observes cfg_ready, prog, busy, done, error
//   slave : the loader side of the same signals
interface row_config_loader_if #(parameter int PROG_W = 552);
  logic start;
  logic abort;
  logic [7:0] cfg_data;
  logic cfg_valid;
  logic cfg_ready;
  logic [PROG_W-1:0] prog;
  logic busy;
  logic done;
  logic error;
  modport master(output start, abort, cfg_data, cfg_valid, input cfg_ready, prog, busy, done, error);
  modport slave(input start, abort, cfg_data, cfg_valid, output cfg_ready, prog, busy, done, error);
endinterface

// File: rtl/row_config_loader.sv
// row_config_loader: streams NUM_BYTES config bytes into a shadow row, verifies an XOR checksum, commits to prog.
//   clb_clk : clock, all state changes on its rising edge
//   rst     : asynchronous active-high reset
//   bus     : row_config_loader_if.slave (start/abort/cfg_data/cfg_valid in; cfg_ready/prog/busy/done/error out)
module row_config_loader #(
  parameter int NUM_BYTES = 69,
  parameter int PROG_W = 8 * NUM_BYTES
) (
  input logic clb_clk,
  input logic rst,
  row_config_loader_if.slave bus
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, CSUM} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] csum;
  logic [PROG_W-1:0] shadow;
  logic [PROG_W-1:0] prog;
  logic ready;
  logic busy;
  logic done;
  logic error;
  assign bus.prog = prog;
  assign bus.cfg_ready = ready;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.error = error;
  // ready and busy are always equal to "state is LOAD or CSUM"; both are set and cleared together
  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      csum <= '0;
      shadow <= '0;
      prog <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state <= LOAD;
            cnt <= '0;
            csum <= '0;
            error <= 1'b0;
            ready <= 1'b1;
            busy <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state <= IDLE;
            ready <= 1'b0;
            busy <= 1'b0;
          end else if (bus.cfg_valid) begin
            shadow[{cnt, 3'b000} +: 8] <= bus.cfg_data;
            csum <= csum ^ bus.cfg_data;
            // hold the counter at LAST rather than wrapping; CSUM does not use it
            if (cnt == LAST) state <= CSUM;
            else cnt <= cnt + 1'b1;
          end
        end
        CSUM: begin
          if (bus.abort) begin
            state <= IDLE;
            ready <= 1'b0;
            busy <= 1'b0;
          end else if (bus.cfg_valid) begin
            state <= IDLE;
            ready <= 1'b0;
            busy <= 1'b0;
            if (bus.cfg_data == csum) begin
              prog <= shadow;
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_row_config_loader.sv
// tb_row_config_loader: directed stimulus with a queue-based reference model checked every cycle.
module tb_row_config_loader;
  localparam int N = 69;
  localparam int W = 552;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  row_config_loader_if #(.PROG_W(W)) b();
  row_config_loader #(.NUM_BYTES(N), .PROG_W(W)) dut(.clb_clk(clk), .rst(rst), .bus(b));
  int total = 0;
  int bad = 0;
  task automatic check(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  // reference model: a loader is either collecting bytes (active) or idle; the collected bytes
  // live in a queue and the checksum is recomputed from the whole queue when it is needed
  bit active = 1'b0;
  logic [7:0] q[$];
  logic [W-1:0] m_prog = '0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  logic [7:0] x;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 1'b0;
      q.delete();
      m_prog = '0;
      m_done = 1'b0;
      m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!active) begin
        if (b.start && !b.abort) begin
          active = 1'b1;
          q.delete();
          m_err = 1'b0;
        end
      end else if (b.abort) begin
        active = 1'b0;
      end else if (b.cfg_valid) begin
        if (q.size() < N) q.push_back(b.cfg_data);
        else begin
          x = 8'h00;
          foreach (q[i]) x ^= q[i];
          if (b.cfg_data == x) begin
            for (int i = 0; i < N; i++) m_prog[8*i +: 8] = q[i];
            m_done = 1'b1;
          end else m_err = 1'b1;
          active = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("ready", W'(b.cfg_ready), W'(active));
      check("busy", W'(b.busy), W'(active));
      check("done", W'(b.done), W'(m_done));
      check("error", W'(b.error), W'(m_err));
      check("prog", b.prog, m_prog);
    end
  end
  task automatic send(input logic [7:0] d, input int gap);
    b.cfg_valid = 1'b1;
    b.cfg_data = d;
    @(negedge clk);
    b.cfg_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("stall_busy", W'(b.busy), W'(1'b1));
    end
  endtask
  task automatic load(input bit idx, input logic [7:0] fill, input int gap, input logic [7:0] cs, input bit hold);
    b.start = 1'b1;
    @(negedge clk);
    if (!hold) b.start = 1'b0;
    for (int k = 0; k < N; k++) send(idx ? 8'(k) : fill, gap);
    send(cs, 0);
    b.start = 1'b0;
  endtask
  initial begin
    b.start = 1'b0;
    b.abort = 1'b0;
    b.cfg_data = 8'h00;
    b.cfg_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_prog", b.prog, '0);
    check("rst_busy", W'(b.busy), '0);
    check("rst_ready", W'(b.cfg_ready), '0);
    check("rst_done", W'(b.done), '0);
    check("rst_error", W'(b.error), '0);
    rst = 1'b0;
    @(negedge clk);
    // happy path: bytes equal to their index, XOR of 0..68 is 0x44
    load(1'b1, 8'h00, 0, 8'h44, 1'b0);
    check("happy_done", W'(b.done), W'(1'b1));
    check("happy_lo", W'(b.prog[7:0]), W'(8'h00));
    check("happy_hi", W'(b.prog[551:544]), W'(8'h44));
    check("happy_mid", W'(b.prog[15:8]), W'(8'h01));
    check("happy_err", W'(b.error), '0);
    @(negedge clk);
    check("happy_done_off", W'(b.done), '0);
    // mismatch: 69 x 0xA5 XORs to 0xA5, checksum 0x00 is wrong
    load(1'b0, 8'hA5, 0, 8'h00, 1'b0);
    check("mis_error", W'(b.error), W'(1'b1));
    check("mis_done", W'(b.done), '0);
    check("mis_prog", W'(b.prog[551:544]), W'(8'h44));
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    check("mis_restart_clr", W'(b.error), '0);
    check("mis_restart_busy", W'(b.busy), W'(1'b1));
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
    check("abort_idle", W'(b.busy), '0);
    // backpressure: same load with three idle cycles after each byte
    load(1'b1, 8'h00, 3, 8'h44, 1'b0);
    check("bp_done", W'(b.done), W'(1'b1));
    check("bp_hi", W'(b.prog[551:544]), W'(8'h44));
    check("bp_b2", W'(b.prog[23:16]), W'(8'h02));
    // abort after 30 bytes, then a clean 0xA5 load
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int k = 0; k < 30; k++) send(8'hFF, 0);
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
    check("ab_busy", W'(b.busy), '0);
    check("ab_prog", W'(b.prog[7:0]), W'(8'h00));
    load(1'b0, 8'hA5, 0, 8'hA5, 1'b0);
    check("ab_done", W'(b.done), W'(1'b1));
    check("ab_lo", W'(b.prog[7:0]), W'(8'hA5));
    check("ab_hi", W'(b.prog[551:544]), W'(8'hA5));
    // asynchronous reset in the middle of a load
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int k = 0; k < 40; k++) send(8'h5A, 0);
    #2 rst = 1'b1;
    b.start = 1'b1;
    b.cfg_valid = 1'b1;
    b.cfg_data = 8'h33;
    #1;
    check("ar_prog", b.prog, '0);
    check("ar_busy", W'(b.busy), '0);
    check("ar_ready", W'(b.cfg_ready), '0);
    repeat (2) @(posedge clk);
    #2;
    check("ar_hold_busy", W'(b.busy), '0);
    b.start = 1'b0;
    b.cfg_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ar_after_busy", W'(b.busy), '0);
    check("ar_after_prog", b.prog, '0);
    // start held through a whole load: no restart inside, single commit
    load(1'b1, 8'h00, 0, 8'h44, 1'b1);
    check("ct_done", W'(b.done), W'(1'b1));
    check("ct_hi", W'(b.prog[551:544]), W'(8'h44));
    @(negedge clk);
    check("ct_idle", W'(b.busy), '0);
    b.start = 1'b1;
    b.abort = 1'b1;
    repeat (2) @(negedge clk);
    check("ct_sa_busy", W'(b.busy), '0);
    check("ct_sa_ready", W'(b.cfg_ready), '0);
    b.start = 1'b0;
    b.abort = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
